// File: rtl/d2p_read_sequencer_pkg.sv
// Shared definitions for the D2P ping-pong buffer read/write controllers.
// Holds the single-bank layer threshold, the word geometry and the read FSM encoding.
package d2p_read_sequencer_pkg;

  // Layers below this value use only bank 0 of the ping-pong buffer.
  localparam int unsigned LAYER_SINGLE_BANK_MAX = 4;

  // Feature elements packed into one RAM word.
  localparam int unsigned WORD_ELEMS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic logic is_single_bank(input logic [3:0] layer);
    return layer < 4'(LAYER_SINGLE_BANK_MAX);
  endfunction

endpackage

// File: rtl/d2p_bank_tracker.sv
// Ping-pong bank ownership tracker: write/read bank pointers, per-bank full
// flags and a sticky overflow flag. Shared by the reader and the writer side.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   single_bank   - hold both pointers at bank 0
//   wr_done       - writer finished filling bank wr_ptr (1-cycle pulse)
//   rd_release    - reader finished draining bank rd_ptr (1-cycle pulse)
//   wr_ptr/rd_ptr - current write / read bank
//   bank_full     - per-bank full flags
//   overflow      - writer completed a bank that was still full (sticky)
module d2p_bank_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       single_bank,
  input  logic       wr_done,
  input  logic       rd_release,
  output logic       wr_ptr,
  output logic       rd_ptr,
  output logic [1:0] bank_full,
  output logic       overflow
);

  logic [1:0] clr_mask;
  logic [1:0] set_mask;
  logic [1:0] full_after_clr;
  logic       conflict;

  // Release is applied before the set, so clear+set of one bank leaves it full without error.
  always_comb begin
    clr_mask       = rd_release ? (2'b01 << rd_ptr) : 2'b00;
    full_after_clr = bank_full & ~clr_mask;
    conflict       = wr_done && full_after_clr[wr_ptr];
    set_mask       = (wr_done && !conflict) ? (2'b01 << wr_ptr) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      bank_full <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      bank_full <= full_after_clr | set_mask;
      if (conflict) overflow <= 1'b1;
      if (single_bank) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (wr_done && !conflict) wr_ptr <= ~wr_ptr;
        if (rd_release)           rd_ptr <= ~rd_ptr;
      end
    end
  end

endmodule

// File: rtl/d2p_read_sequencer.sv
// Read-side controller of the D2P ping-pong feature buffer. Waits for a full
// bank, sweeps it channel by channel into the pointwise 1x1 array, pulses
// point11_done and releases the bank back to the writer.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   layer             - current layer; below the threshold only bank 0 is used
//   bank_wr_done      - writer finished a bank (1-cycle pulse)
//   point_ready       - pointwise array accepts a channel this cycle
//   buf_dout          - RAM port-B read data (1-cycle latency)
//   buf_addrb/buf_enb - RAM port-B address and read enable
//   point_channel_sel - channel currently issued
//   point_input       - word presented to the pointwise array
//   point_valid       - point_input holds the word of an earlier issue
//   point11_done      - 1-cycle pulse after the last channel of a bank
//   bank_full         - per-bank full flags (writer back-pressure)
//   overflow          - sticky bank overflow error
module d2p_read_sequencer
  import d2p_read_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHANNELS   = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [3:0]                            layer,
  input  logic                                  bank_wr_done,
  input  logic                                  point_ready,
  input  logic [DATA_WIDTH*WORD_ELEMS-1:0]      buf_dout,
  output logic [$clog2(CHANNELS/WORD_ELEMS):0]  buf_addrb,
  output logic                                  buf_enb,
  output logic [7:0]                            point_channel_sel,
  output logic [DATA_WIDTH*WORD_ELEMS-1:0]      point_input,
  output logic                                  point_valid,
  output logic                                  point11_done,
  output logic [1:0]                            bank_full,
  output logic                                  overflow
);

  localparam int unsigned WORDS   = CHANNELS / WORD_ELEMS;
  localparam int unsigned WIDX    = $clog2(WORDS);
  localparam int unsigned DW      = DATA_WIDTH * WORD_ELEMS;
  localparam logic [7:0]  LAST_CH = 8'(CHANNELS - 1);

  seq_state_t    state_q, state_d;
  logic [7:0]    chan_q, chan_d;
  logic          enb_c;
  logic          release_c;
  logic          done_q;
  logic          single;
  logic          rd_ptr;
  logic          wr_ptr;
  logic          valid_q1, valid_q2;
  logic [DW-1:0] data_q;

  assign single = is_single_bank(layer);

  d2p_bank_tracker u_tracker (
    .clk        (clk),
    .rst        (rst),
    .single_bank(single),
    .wr_done    (bank_wr_done),
    .rd_release (release_c),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .bank_full  (bank_full),
    .overflow   (overflow)
  );

  // State and channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      chan_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      done_q  <= (state_d == DONE);
    end
  end

  // Next-state, channel advance and RAM read enable.
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    enb_c     = 1'b0;
    release_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bank_full[rd_ptr]) begin
          state_d = READ;
          chan_d  = 8'd0;
        end
      end
      READ: begin
        if (point_ready) begin
          enb_c = 1'b1;
          if (chan_q == LAST_CH) state_d = DONE;
          else                   chan_d  = chan_q + 8'd1;
        end
      end
      DONE: begin
        release_c = 1'b1;
        chan_d    = 8'd0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output pipeline; single-bank mode adds one register stage on data and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q1 <= 1'b0;
      valid_q2 <= 1'b0;
      data_q   <= '0;
    end else begin
      valid_q1 <= enb_c;
      valid_q2 <= valid_q1;
      if (valid_q1) data_q <= buf_dout;
    end
  end

  assign buf_enb           = enb_c;
  assign buf_addrb         = {rd_ptr, WIDX'(chan_q[7:3])};
  assign point_channel_sel = chan_q;
  assign point11_done      = done_q;
  assign point_valid       = single ? valid_q2 : valid_q1;
  assign point_input       = single ? data_q : buf_dout;

endmodule

// File: doc/d2p_read_sequencer.md
Name: d2p_read_sequencer

Overview:
Read-side controller for the depthwise-to-pointwise ping-pong feature buffer (the `D2P_buffer` dual-port RAM). It tracks which bank the depthwise writer has filled and sweeps that bank channel by channel into the pointwise 1x1 array. It generates the port-B address, `point_channel_sel` and a `point11_done` pulse, then releases the bank back to the writer. It sits between `D2P_buffer` port B and the pointwise compute stage.

Parameters:
- DATA_WIDTH, 8, bits per feature element; one RAM word = 8 elements.
- CHANNELS, 32, pointwise input channels per bank; must be a multiple of 8, max 128.
- WORDS, CHANNELS/8, RAM words per bank; localparam, power of two.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- layer  in  4  current network layer; layer<4 selects single-bank mode.
- bank_wr_done  in  1  one-cycle pulse: writer has finished filling its current bank.
- point_ready  in  1  pointwise array accepts a channel this cycle.
- buf_dout  in  DATA_WIDTH*8  RAM port-B read data, 1-cycle latency.
- buf_addrb  out  1+log2(WORDS)  port-B address = {rd_bank, channel_sel>>3}.
- buf_enb  out  1  port-B read enable.
- point_channel_sel  out  8  channel index currently issued.
- point_input  out  DATA_WIDTH*8  word presented to the pointwise array.
- point_valid  out  1  point_input is valid for point_channel_sel issued 1 cycle earlier (2 cycles in single-bank mode).
- point11_done  out  1  one-cycle pulse after the last channel of a bank is issued.
- bank_full  out  2  per-bank full flags, visible to the writer for back-pressure.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0; state IDLE; wr_ptr=rd_ptr=0; bank_full=2'b00; channel_sel=0.
- wr_ptr toggles on every bank_wr_done.
  - Exception: in single-bank mode (layer<4), wr_ptr and rd_ptr are held at 0.
- bank_wr_done sets bank_full[wr_ptr].
  - If that bit is already set and not cleared in the same cycle: set overflow (sticky until rst), do not toggle wr_ptr.
- Simultaneous clear and set of the same bank: the clear applies first, then the set, so the flag ends at 1 with no overflow.
- FSM:
  - IDLE: if bank_full[rd_ptr] -> READ, channel_sel=0.
  - READ: while point_ready, assert buf_enb and increment channel_sel by 1 per cycle; if point_ready=0, hold channel_sel and deassert buf_enb.
    - When channel_sel==CHANNELS-1 is accepted -> DONE.
  - DONE (1 cycle): pulse point11_done, clear bank_full[rd_ptr], toggle rd_ptr (double-bank mode only) -> IDLE.
    - If the next bank is already full, IDLE proceeds to READ on the following cycle, giving 1 bubble cycle per bank.
- buf_addrb is combinational from rd_ptr and channel_sel.
- point_valid is buf_enb delayed 1 cycle.
  - In single-bank mode, point_input and point_valid get one extra register stage (2-cycle latency total).
  - In double-bank mode, point_input = buf_dout directly.
- A change of layer is only legal in IDLE with bank_full==0; otherwise behaviour is unspecified.
- rst mid-READ: abandon the sweep immediately, no point11_done, flags cleared.
- Width rules:
  - channel_sel is 8 bits and compares against CHANNELS-1 exactly; there is no wrap beyond that.
  - The word index is channel_sel[7:3] truncated to log2(WORDS) bits.

Decomposition:
- Shared package/header holds:
  - the LAYER_SINGLE_BANK_MAX=4 threshold, also used by the writer side;
  - the FSM state encodings IDLE/READ/DONE;
  - the WORD_ELEMS=8 constant.
- One natural sub-module: `d2p_bank_tracker`.
  - Contents: wr_ptr, rd_ptr, the bank_full flags and overflow logic.
  - Reuse: the writer-side controller can instantiate the same tracker for its back-pressure view.
- The FSM and output pipeline stay in the top module.

Test Plan:
- Basic sweep:
  - Stimulus: rst, layer=5, bank_wr_done pulse, point_ready=1 held.
  - Response: buf_addrb walks 0,0..(8x),1..,3 over 32 cycles; point11_done pulses 1 cycle after channel 31; bank_full goes 01->00; rd_ptr=1.
- Ping-pong:
  - Stimulus: two bank_wr_done pulses 5 cycles apart.
  - Response: bank_full=11; the second sweep uses addresses 4..7 and starts exactly 1 bubble cycle after point11_done; overflow stays 0.
- Overflow:
  - Stimulus: three bank_wr_done pulses with point_ready=0.
  - Response: overflow=1 after the third pulse; wr_ptr is unchanged by it; bank_full=11.
- Stall:
  - Stimulus: point_ready toggling 1,0,1,0.
  - Response: channel_sel advances only on ready cycles; point_valid follows buf_enb by 1 cycle; the sweep completes in 64 cycles.
- Single-bank mode:
  - Stimulus: layer=2, two bank_wr_done pulses, each after the previous point11_done.
  - Response: buf_addrb is always in 0..3; point_valid lags issue by 2 cycles; data matches the RAM model.
- Reset mid-sweep:
  - Stimulus: assert rst at channel 17.
  - Response: next cycle all outputs are 0, there is no point11_done, and bank_full=00.
